// File: rtl/atomik_pkg.sv
// Shared constants and enable-priority encoding for the XOR-delta state register.
package atomik_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    OP_NONE     = 2'd0,
    OP_ROLLBACK = 2'd1,
    OP_LOAD     = 2'd2,
    OP_ACCUM    = 2'd3
  } op_e;

  // Accumulator priority: rollback beats load, load beats accumulate.
  function automatic op_e decode_op(input logic rollback_en, input logic load_en,
                                    input logic accumulate_en);
    if (rollback_en)        return OP_ROLLBACK;
    else if (load_en)       return OP_LOAD;
    else if (accumulate_en) return OP_ACCUM;
    else                    return OP_NONE;
  endfunction

endpackage

// File: rtl/atomik_edge_sensor_imu_fusion_if.sv
// Command/data bundle between the IMU sample front-end (master) and the state register (slave).
interface atomik_edge_sensor_imu_fusion_if
  import atomik_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  // Each enable is a single-cycle command acted on at the rising edge where it is high;
  // there is no back-pressure, so the slave accepts every command in the cycle it is presented.
  logic                  load_en;
  logic                  accumulate_en;
  logic                  read_en;
  logic                  rollback_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  accumulator_zero;

  modport master (
    output load_en, accumulate_en, read_en, rollback_en, data_in,
    input  data_out, accumulator_zero
  );

  modport slave (
    input  load_en, accumulate_en, read_en, rollback_en, data_in,
    output data_out, accumulator_zero
  );

endinterface

// File: rtl/atomik_delta_acc.sv
// Delta accumulator: XOR-folds sensor deltas, clears on load/rollback, flags an all-zero value.
module atomik_delta_acc
  import atomik_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] delta,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  acc_zero
);

  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    unique case (op)
      OP_ROLLBACK, OP_LOAD: acc_d = '0;
      OP_ACCUM:             acc_d = acc_q ^ delta;
      default:              acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc      = acc_q;
  assign acc_zero = (acc_q == '0);

endmodule

// File: rtl/atomik_edge_sensor_imu_fusion.sv
// XOR-delta state register: base register, delta accumulator and registered reconstruction read.
module atomik_edge_sensor_imu_fusion
  import atomik_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  atomik_edge_sensor_imu_fusion_if.slave  bus
);

  op_e                   op;
  logic [DATA_WIDTH-1:0] acc;
  logic                  acc_zero;
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] base_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  always_comb begin
    op = decode_op(bus.rollback_en, bus.load_en, bus.accumulate_en);
  end

  atomik_delta_acc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .delta    (bus.data_in),
    .acc      (acc),
    .acc_zero (acc_zero)
  );

  // Base follows load_en directly: a rollback in the same cycle still lets the load land.
  // The read samples pre-edge base/accumulator, so same-cycle updates show on the next read.
  always_comb begin
    base_d     = bus.load_en ? bus.data_in : base_q;
    data_out_d = bus.read_en ? (base_q ^ acc) : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      data_out_q <= '0;
    end else begin
      base_q     <= base_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out         = data_out_q;
  assign bus.accumulator_zero = acc_zero;

endmodule

// File: tb/tb_atomik_edge_sensor_imu_fusion.sv
// Scenario bench for the XOR-delta state register with a reference model and read scoreboard.
module tb_atomik_edge_sensor_imu_fusion;

  localparam int W = 64;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_base;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_dout;

  atomik_edge_sensor_imu_fusion_if #(.DATA_WIDTH(W)) bus ();

  atomik_edge_sensor_imu_fusion #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one clock cycle of stimulus, model updated and read results queued
  task automatic drive_cycle(input logic rs, input logic ld, input logic ac, input logic rd,
                             input logic rb, input logic [W-1:0] din);
    @(negedge clk);
    rst               = rs;
    bus.load_en       = ld;
    bus.accumulate_en = ac;
    bus.read_en       = rd;
    bus.rollback_en   = rb;
    bus.data_in       = din;
    if (rs) begin
      if (rd) exp_q.push_back('0);
      m_base = '0;
      m_acc  = '0;
      m_dout = '0;
    end else begin
      if (rd) begin
        m_dout = m_base ^ m_acc;
        exp_q.push_back(m_dout);
      end
      if (rb)      m_acc = '0;
      else if (ld) m_acc = '0;
      else if (ac) m_acc = m_acc ^ din;
      if (ld) m_base = din;
    end
    @(posedge clk);
    #1;
    rst               = 1'b0;
    bus.load_en       = 1'b0;
    bus.accumulate_en = 1'b0;
    bus.read_en       = 1'b0;
    bus.rollback_en   = 1'b0;
    bus.data_in       = '0;
  endtask

  task automatic test_reset;
    logic [W-1:0] exp;
    drive_cycle(1, 0, 0, 0, 0, '0);
    drive_cycle(1, 0, 0, 0, 0, '0);
    checks++;
    if (bus.data_out !== '0) begin
      failures++;
      $display("FAIL reset_data_out got=%h want=%h", bus.data_out, {W{1'b0}});
    end
    checks++;
    if (bus.accumulator_zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_acc_zero got=%b want=1", bus.accumulator_zero);
    end
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp) begin
      failures++;
      $display("FAIL reset_read got=%h want=%h", bus.data_out, exp);
    end
  endtask

  task automatic test_load_accum_read;
    logic [W-1:0] exp;
    drive_cycle(0, 1, 0, 0, 0, 64'hAAAAAAAAAAAAAAAA);
    checks++;
    if (bus.accumulator_zero !== 1'b1) begin
      failures++;
      $display("FAIL load_acc_zero got=%b want=1", bus.accumulator_zero);
    end
    drive_cycle(0, 0, 1, 0, 0, 64'h5555555555555555);
    checks++;
    if (bus.accumulator_zero !== 1'b0) begin
      failures++;
      $display("FAIL accum_acc_zero got=%b want=0", bus.accumulator_zero);
    end
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== 64'hFFFFFFFFFFFFFFFF) begin
      failures++;
      $display("FAIL load_accum_read got=%h want=%h", bus.data_out, 64'hFFFFFFFFFFFFFFFF);
    end
    // data_out holds with no read
    drive_cycle(0, 0, 0, 0, 0, 64'h1);
    checks++;
    if (bus.data_out !== 64'hFFFFFFFFFFFFFFFF) begin
      failures++;
      $display("FAIL hold_data_out got=%h want=%h", bus.data_out, 64'hFFFFFFFFFFFFFFFF);
    end
  endtask

  task automatic test_self_inverse;
    logic [W-1:0] exp;
    drive_cycle(0, 0, 1, 0, 0, 64'h1234567890ABCDEF);
    drive_cycle(0, 0, 1, 0, 0, 64'h1234567890ABCDEF);
    checks++;
    if (dut.u_acc.acc_q !== 64'h5555555555555555) begin
      failures++;
      $display("FAIL self_inverse_acc got=%h want=%h", dut.u_acc.acc_q, 64'h5555555555555555);
    end
    checks++;
    if (bus.accumulator_zero !== 1'b0) begin
      failures++;
      $display("FAIL self_inverse_acc_zero got=%b want=0", bus.accumulator_zero);
    end
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== 64'hFFFFFFFFFFFFFFFF) begin
      failures++;
      $display("FAIL self_inverse_read got=%h want=%h", bus.data_out, 64'hFFFFFFFFFFFFFFFF);
    end
  endtask

  task automatic test_rollback;
    logic [W-1:0] exp;
    drive_cycle(0, 0, 1, 0, 0, 64'h1111111111111111);
    drive_cycle(0, 0, 0, 0, 1, 64'h2222222222222222);
    checks++;
    if (bus.accumulator_zero !== 1'b1) begin
      failures++;
      $display("FAIL rollback_acc_zero got=%b want=1", bus.accumulator_zero);
    end
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== 64'hAAAAAAAAAAAAAAAA) begin
      failures++;
      $display("FAIL rollback_read got=%h want=%h", bus.data_out, 64'hAAAAAAAAAAAAAAAA);
    end
  endtask

  task automatic test_simultaneous;
    logic [W-1:0] exp;
    drive_cycle(0, 1, 1, 0, 0, 64'h0F0F0F0F0F0F0F0F);
    checks++;
    if (dut.base_q !== 64'h0F0F0F0F0F0F0F0F) begin
      failures++;
      $display("FAIL load_accum_base got=%h want=%h", dut.base_q, 64'h0F0F0F0F0F0F0F0F);
    end
    checks++;
    if (bus.accumulator_zero !== 1'b1) begin
      failures++;
      $display("FAIL load_accum_acc_zero got=%b want=1", bus.accumulator_zero);
    end
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== 64'h0F0F0F0F0F0F0F0F) begin
      failures++;
      $display("FAIL load_accum_read got=%h want=%h", bus.data_out, 64'h0F0F0F0F0F0F0F0F);
    end
    drive_cycle(0, 0, 1, 1, 0, 64'hFF);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== 64'h0F0F0F0F0F0F0F0F) begin
      failures++;
      $display("FAIL read_accum_pre got=%h want=%h", bus.data_out, 64'h0F0F0F0F0F0F0F0F);
    end
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== 64'h0F0F0F0F0F0F0FF0) begin
      failures++;
      $display("FAIL read_accum_post got=%h want=%h", bus.data_out, 64'h0F0F0F0F0F0F0FF0);
    end
    // rollback + load: base still loads, accumulator cleared
    drive_cycle(0, 0, 1, 0, 0, 64'h3C);
    drive_cycle(0, 1, 0, 0, 1, 64'hDEADBEEF00000001);
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== 64'hDEADBEEF00000001) begin
      failures++;
      $display("FAIL rollback_load_read got=%h want=%h", bus.data_out, 64'hDEADBEEF00000001);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] exp;
    drive_cycle(0, 0, 1, 0, 0, 64'hFF);
    drive_cycle(1, 0, 1, 0, 0, 64'h1);
    checks++;
    if (bus.accumulator_zero !== 1'b1 || bus.data_out !== '0 || dut.base_q !== '0) begin
      failures++;
      $display("FAIL reset_mid_state got acc_zero=%b data_out=%h base=%h want 1/0/0",
               bus.accumulator_zero, bus.data_out, dut.base_q);
    end
    drive_cycle(0, 0, 0, 1, 0, '0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.data_out !== exp || exp !== '0) begin
      failures++;
      $display("FAIL reset_mid_read got=%h want=%h", bus.data_out, {W{1'b0}});
    end
  endtask

  task automatic test_random;
    logic [W-1:0] din;
    logic [W-1:0] exp;
    for (int i = 0; i < 300; i++) begin
      din = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) din[W-1:16] = '0;
      drive_cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), din);
      checks++;
      if (bus.accumulator_zero !== (m_acc == '0)) begin
        failures++;
        $display("FAIL rand_acc_zero cyc=%0d got=%b want=%b", i, bus.accumulator_zero, (m_acc == '0));
      end
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (bus.data_out !== exp) begin
          failures++;
          $display("FAIL rand_read cyc=%0d got=%h want=%h", i, bus.data_out, exp);
        end
      end
      checks++;
      if (bus.data_out !== m_dout) begin
        failures++;
        $display("FAIL rand_hold cyc=%0d got=%h want=%h", i, bus.data_out, m_dout);
      end
    end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    m_base            = '0;
    m_acc             = '0;
    m_dout            = '0;
    rst               = 1'b1;
    bus.load_en       = 1'b0;
    bus.accumulate_en = 1'b0;
    bus.read_en       = 1'b0;
    bus.rollback_en   = 1'b0;
    bus.data_in       = '0;
    test_reset();
    test_load_accum_read();
    test_self_inverse();
    test_rollback();
    test_simultaneous();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atomik_edge_sensor_imu_fusion.md
Name: atomik_edge_sensor_imu_fusion

Overview:
- XOR-delta state register for the edge-sensor IMU fusion path.
- Holds a loaded base state and a delta accumulator. New sensor deltas are XOR-folded into the accumulator.
- A read returns the reconstructed state: base XOR accumulator. Rollback discards all deltas since the last load.
- Sits between the IMU sample front-end and the fusion consumer; single clock domain.

Parameters:
- DATA_WIDTH, 64, width of state, delta and output words.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_en  input  1  on the clock edge: base state <= data_in, accumulator <= 0.
- accumulate_en  input  1  on the clock edge: accumulator <= accumulator XOR data_in.
- read_en  input  1  on the clock edge: data_out <= base XOR accumulator.
- rollback_en  input  1  on the clock edge: accumulator <= 0; base state unchanged.
- data_in  input  DATA_WIDTH  load value or delta.
- data_out  output  DATA_WIDTH  registered reconstructed state.
- accumulator_zero  output  1  high when accumulator == 0 (combinational from the register).

Behaviour:
- Reset: when rst is high at a clock edge, base, accumulator and data_out all become 0. accumulator_zero therefore reads 1. Reset overrides every enable.
- Accumulator priority when several enables are high in the same cycle: rollback_en > load_en > accumulate_en.
  - rollback + load: accumulator <= 0, and base still loads data_in.
  - rollback + accumulate: the accumulate is dropped.
  - load + accumulate: accumulator <= 0 and base <= data_in; the delta is dropped.
- Base state is written only by load_en or rst.
- read_en is independent of the other enables. It samples the pre-edge base and accumulator, so a same-cycle load/accumulate/rollback is not yet reflected.
- Read latency is one cycle: data_out is valid after the edge where read_en = 1, and holds its value until the next read or reset.
- All arithmetic is bitwise XOR at full DATA_WIDTH. There is no carry and no overflow.
- Applying the same delta twice restores the accumulator exactly (self-inverse property).
- accumulator_zero depends only on the accumulator; the base value does not affect it.
- With no enable asserted, all registers hold their values.
- A reset asserted mid-sequence takes effect on that edge; no partial state is retained.

Decomposition:
- Shared package atomik_pkg:
  - default DATA_WIDTH constant (64);
  - op-priority encoding (OP_NONE, OP_ROLLBACK, OP_LOAD, OP_ACCUM) used by the enable decoder.
- One natural sub-module, atomik_delta_acc. It contains the accumulator register, the XOR update, the clear/rollback logic and the zero detect.
- The top level holds the base register, the read-output register and the priority decode.

Test Plan:
1. Reset: assert rst for 2 cycles with all enables at 0. Required: data_out = 0 and accumulator_zero = 1.
2. Load then accumulate then read:
   - load 64'hAAAAAAAAAAAAAAAA;
   - accumulate 64'h5555555555555555 (accumulator_zero goes 0);
   - read.
   Required: data_out = 64'hFFFFFFFFFFFFFFFF one cycle after read_en.
3. Self-inverse: after scenario 2, accumulate 64'h1234567890ABCDEF twice, then read.
   - Required: accumulator returns to 64'h5555555555555555 and accumulator_zero = 0.
   - Required: data_out = 64'hFFFFFFFFFFFFFFFF.
4. Rollback: accumulate 64'h1111111111111111, then pulse rollback_en, then read.
   - Required: accumulator_zero = 1.
   - Required: data_out = 64'hAAAAAAAAAAAAAAAA (base only).
5. Simultaneous enables:
   - With load_en and accumulate_en high together, data_in = 64'h0F0F0F0F0F0F0F0F. Required: base = 64'h0F0F0F0F0F0F0F0F, accumulator_zero = 1, and a later read returns 64'h0F0F0F0F0F0F0F0F.
   - With read_en and accumulate_en high together (delta 64'hFF), data_out shows the pre-accumulate value. A following read shows 64'h0F0F0F0F0F0F0FF0.
6. Reset mid-operation: assert rst on the same edge as accumulate_en with delta 64'h1. Required: all state is 0, accumulator_zero = 1, and the next read gives data_out = 0.
